blk_load_sched: RTL
===================

BLK_LOAD_SCHED -- requirements
Module: blk_load_sched

Interface
REQ-001 The block SHALL have parameter AW, default 18: SRAM address width.
REQ-002 The block SHALL have parameter DW, default 16: SRAM data and buffer word width.
REQ-003 The block SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports req0 and req1, input, 1 each: level block-load requests from requester 0 and requester 1.
REQ-006 The block SHALL have ports base0 and base1, input, AW each: SRAM base address of the 8x8 block for each requester.
REQ-007 The block SHALL have ports gnt0 and gnt1, output, 1 each: one-cycle grant pulses.
REQ-008 The block SHALL have port busy, output, 1: a transfer is in progress.
REQ-009 The block SHALL have port done, output, 1: one-cycle transfer-complete pulse.
REQ-010 The block SHALL have port owner, output, 1: index of the requester being served.
REQ-011 The block SHALL have port sram_rd_en, output, 1: SRAM read request.
REQ-012 The block SHALL have port sram_addr, output, AW: SRAM read address.
REQ-013 The block SHALL have port sram_ready, input, 1: SRAM accepts the read this cycle.
REQ-014 The block SHALL have port sram_rdata, input, DW: read data, valid exactly one cycle after an accepted read.
REQ-015 The block SHALL have ports buf_we (output, 1), buf_row (output, 3), buf_col (output, 3) and buf_wdata (output, DW): the 8x8 block-buffer write port.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-017 In IDLE with any req high, the block SHALL choose a requester, latch its base and owner, and enter ISSUE on the next edge.
REQ-018 With exactly one req high in IDLE, that requester SHALL be chosen.
REQ-019 With both req high in IDLE, the requester named by the round-robin pointer SHALL be chosen; the pointer resets to 0.
REQ-020 After each DONE, the pointer SHALL point to the requester not just served.
REQ-021 gnt0 or gnt1 (matching owner) SHALL be high only in the first ISSUE cycle of a transfer.
REQ-022 req changes while busy SHALL be ignored.
REQ-023 A req dropped before being sampled in IDLE SHALL not be granted.
REQ-024 ISSUE: sram_rd_en SHALL be 1 and sram_addr SHALL equal latched base + idx, modulo 2^AW (wrap at the top of the address space), where 6-bit idx starts at 0.
REQ-025 ISSUE: idx SHALL increment only on a cycle with sram_rd_en and sram_ready both high; with sram_ready low, sram_addr and idx SHALL hold.
REQ-026 ISSUE SHALL go to DRAIN on the edge ending the cycle in which idx 63 is accepted.
REQ-027 The cycle after each accepted read, buf_we SHALL be 1, with buf_row = accepted idx[5:3], buf_col = accepted idx[2:0] and buf_wdata = sram_rdata.
REQ-028 buf_we SHALL be 0 in every other cycle; exactly 64 writes SHALL occur per transfer, row-major.
REQ-029 DRAIN SHALL last one cycle, during which the idx-63 buffer write occurs; sram_rd_en SHALL be 0 there.
REQ-030 DONE SHALL last one cycle with done = 1, then return to IDLE; the block SHALL not grant in DONE.
REQ-031 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-032 owner SHALL hold the served index from grant through DONE.
REQ-033 Latency with sram_ready held high: req sampled in IDLE at cycle T gives gnt and the first read at T+1, the first buf_we at T+2, the last read at T+64, the last buf_we at T+65, done at T+66 and IDLE at T+67.
REQ-034 The earliest next grant SHALL be at T+68.

Reset
REQ-035 reset_n low SHALL immediately force state to IDLE, idx to 0, RR pointer to 0, and latched base and owner to 0.
REQ-036 reset_n low SHALL force all outputs (gnt0, gnt1, busy, done, owner, sram_rd_en, sram_addr, buf_we, buf_row, buf_col, buf_wdata) to 0.
REQ-037 Reset mid-transfer SHALL abandon the transfer: no done, no further buf_we, and no pending data write after release.
REQ-038 The first grant after reset_n rises SHALL follow REQ-017..REQ-019.

Verification
REQ-039 Single request: req0 = 1, base0 = 0x00100, sram_ready = 1 -> gnt0 at T+1; addresses 0x00100..0x0013F; 64 buf_we with (row,col) (0,0)..(7,7) and data matching; done at T+66.
REQ-040 Contention: req0 = req1 = 1 held -> grants alternate 0,1,0 across three transfers; owner matches each grant.
REQ-041 Backpressure: sram_ready low on every third cycle -> sram_addr held while low; still exactly 64 in-order writes; done one cycle after DRAIN.
REQ-042 Wrap: base1 = 0x3FFF0, AW = 18 -> sram_addr goes 0x3FFFF then 0x00000; the final address is 0x0002F.
REQ-043 Reset at idx 30: reset_n pulled low -> all outputs 0 the same cycle; no done; a new req0 after release starts at idx 0 with gnt0.
REQ-044 Request ignored while busy: req1 pulsed for one cycle during ISSUE -> no gnt1 is ever issued for it.

Source files
------------

// File: rtl/blk_load_sched.sv
// blk_load_sched: round-robin scheduler for two requesters. A granted transfer
// streams one 8x8 block (64 words) from SRAM into the block buffer in row-major
// order. The buffer write trails each accepted read by one cycle.
module blk_load_sched #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] base0,
  input  logic [AW-1:0] base1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          busy,
  output logic          done,
  output logic          owner,
  output logic          sram_rd_en,
  output logic [AW-1:0] sram_addr,
  input  logic          sram_ready,
  input  logic [DW-1:0] sram_rdata,
  output logic          buf_we,
  output logic [2:0]    buf_row,
  output logic [2:0]    buf_col,
  output logic [DW-1:0] buf_wdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [AW-1:0] base_q, base_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic          first_q, first_d;
  logic          wr_q, wr_d;
  logic [5:0]    wr_idx_q, wr_idx_d;

  logic any_req;
  logic pick;
  logic accept;

  // Arbitration and read handshake: a lone requester wins, otherwise the RR pointer decides
  always_comb begin
    any_req = req0 | req1;
    pick    = (req0 & req1) ? rr_q : req1;
    accept  = (state_q == ISSUE) & sram_ready;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (accept && (idx_q == 6'd63)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: request latch, read index, RR pointer, trailing buffer write
  always_comb begin
    idx_d    = idx_q;
    base_d   = base_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    first_d  = 1'b0;
    wr_d     = accept;
    wr_idx_d = idx_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          base_d  = pick ? base1 : base0;
          owner_d = pick;
          idx_d   = '0;
          first_d = 1'b1;
        end
      end
      ISSUE: begin
        if (accept) idx_d = idx_q + 6'd1;
      end
      DONE: begin
        rr_d = ~owner_q;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      base_q   <= '0;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      first_q  <= 1'b0;
      wr_q     <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      idx_q    <= idx_d;
      base_q   <= base_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      first_q  <= first_d;
      wr_q     <= wr_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  // Output decode; everything is zero whenever its qualifying condition is absent
  always_comb begin
    gnt0       = first_q & ~owner_q;
    gnt1       = first_q & owner_q;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    owner      = owner_q;
    sram_rd_en = (state_q == ISSUE);
    sram_addr  = '0;
    if (state_q == ISSUE) sram_addr = base_q + AW'(idx_q);
    buf_we     = wr_q;
    buf_row    = '0;
    buf_col    = '0;
    buf_wdata  = '0;
    if (wr_q) begin
      buf_row   = wr_idx_q[5:3];
      buf_col   = wr_idx_q[2:0];
      buf_wdata = sram_rdata;
    end
  end

endmodule
